pipe_stage_regs: RTL and testbench
==================================

// Module: pipe_stage_regs
// PURPOSE
//  Pipeline-register block that consumes the hazard controls StallF, StallD, FlushD and FlushE.
//  It holds three registers: the PC register (IF), the IF/ID register and the ID/EX register.
//  Each stage carries a valid bit, so flushed bubbles are tracked explicitly.
//  It also keeps stall and flush event counters for performance debug.
//  Sits between fetch/decode datapath logic and the execute stage of the 5-stage RV32I core.
// PARAMETERS
//  XLEN      32            datapath width (PC, instr, operands, immediate)
//  CTRL_W    12            width of packed decode-control bundle (RegWrite, ResultSrc, MemWrite, ALUCtrl, ...)
//  RESET_PC  32'h0000_0000 PC value loaded on reset
//  CNT_W     32            width of stall/flush event counters
// PORTS
//  clk         in  1       rising-edge clock
//  reset       in  1       asynchronous, active-high reset
//  StallF      in  1       hold PC register
//  StallD      in  1       hold IF/ID register
//  FlushD      in  1       clear IF/ID register (insert bubble)
//  FlushE      in  1       clear ID/EX register (insert bubble)
//  PCNextF     in  XLEN    next PC from PC mux
//  InstrF      in  XLEN    fetched instruction
//  PCPlus4F    in  XLEN    PC+4 from fetch adder
//  PCF         out XLEN    current fetch PC
//  InstrD      out XLEN    decode-stage instruction
//  PCD         out XLEN    decode-stage PC
//  PCPlus4D    out XLEN    decode-stage PC+4
//  ValidD      out 1       decode stage holds a real instruction
//  CtrlD       in  CTRL_W  decoded control bundle
//  RD1D, RD2D  in  XLEN    register-file read data
//  ImmExtD     in  XLEN    extended immediate
//  Rs1D, Rs2D  out 5       source register fields, taken from InstrD[19:15] and InstrD[24:20]
//  RdD         out 5       destination register field, taken from InstrD[11:7]
//  CtrlE       out CTRL_W  execute-stage control bundle
//  RD1E, RD2E  out XLEN    execute-stage operands
//  ImmExtE     out XLEN    execute-stage immediate
//  PCE         out XLEN    execute-stage PC
//  PCPlus4E    out XLEN    execute-stage PC+4
//  Rs1E, Rs2E  out 5       execute-stage source registers
//  RdE         out 5       execute-stage destination register
//  ValidE      out 1       execute stage holds a real instruction
//  StallCnt    out CNT_W   cycles with StallD=1 and FlushD=0
//  FlushCnt    out CNT_W   cycles with FlushD=1
// BEHAVIOUR
//  Reset (async, immediate on assertion):
//   - PCF=RESET_PC.
//   - Every other register output is 0, including ValidD, ValidE, StallCnt and FlushCnt.
//   - CtrlE=0 encodes a no-op: no register write and no memory write.
//  Release from reset:
//   - ValidD=1 from the 1st clk edge after reset is deasserted.
//   - The first valid fetch is at PCF=RESET_PC.
//  PC register, each edge:
//   - StallF=1: hold PCF.
//   - Otherwise: PCF<=PCNextF.
//  IF/ID register, priority FlushD > StallD > load:
//   - FlushD=1: all fields<=0 and ValidD<=0 (InstrD=0, so RdD/Rs1D/Rs2D=0).
//   - StallD=1: hold all fields.
//   - Otherwise: capture InstrF, PCF, PCPlus4F; ValidD<=1.
//  ID/EX register, priority FlushE > load (no stall input; EX never stalls):
//   - FlushE=1: all fields<=0 and ValidE<=0.
//   - Otherwise: capture CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD; ValidE<=ValidD.
//   - If ValidD=0, CtrlE<=0 regardless of the CtrlD input (a bubble never carries control).
//  Simultaneous events:
//   - StallD=1 with FlushD=1: flush wins. This arises when a taken branch coincides with a load-use.
//   - StallF=1 with FlushD=1: PC holds while IF/ID clears.
//  Counters:
//   - Count +1 per qualifying cycle, sampled at the clk edge.
//   - Wrap modulo 2^CNT_W; no saturation.
//  Latency: 1 cycle per stage; there are no combinational paths from inputs to outputs except the Rs/Rd field slices.
//  Reset asserted mid-operation: all state clears in the same cycle. No partial-instruction state survives.
// TESTING
//  1. Reset with RESET_PC=0x100, then release; drive PCNextF=PCF+4 -> PCF sequence 0x100, 0x104, 0x108; ValidD=1 from the 1st edge.
//  2. Load-use: assert StallF=StallD=FlushE=1 for 1 cycle -> PCF and InstrD held; ValidE=0 and CtrlE=0 next cycle; StallCnt=1.
//  3. Taken branch: assert FlushD=FlushE=1 for 1 cycle -> ValidD=0, ValidE=0, InstrD=0, RdE=0 next cycle; FlushCnt=1.
//  4. StallD=1 and FlushD=1 together -> IF/ID cleared (flush wins); StallCnt unchanged; FlushCnt+1.
//  5. Assert reset asynchronously mid-cycle while InstrD=0x00A00093 -> all outputs reach reset values before the next edge; PCF=RESET_PC.
//  6. Preload StallCnt to 2^CNT_W-1 (CNT_W=4 build), apply 1 stall cycle -> StallCnt wraps to 0.

Source files
------------

// File: rtl/pipe_stage_regs.sv
// Pipeline registers for the PC (IF), IF/ID and ID/EX stages of the RV32I core.
// Applies stall/flush hazard controls and keeps stall/flush event counters.
module pipe_stage_regs #(
  parameter int              XLEN     = 32,
  parameter int              CTRL_W   = 12,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   PCNextF,
  input  logic [XLEN-1:0]   InstrF,
  input  logic [XLEN-1:0]   PCPlus4F,
  output logic [XLEN-1:0]   PCF,
  output logic [XLEN-1:0]   InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  output logic [4:0]        Rs1D,
  output logic [4:0]        Rs2D,
  output logic [4:0]        RdD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic              ValidE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else if (!StallF) begin
      PCF <= PCNextF;
    end
  end

  // IF/ID: flush beats stall so a taken branch kills a stalled load-use slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= '0;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= '0;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];
  assign RdD  = InstrD[11:7];

  // ID/EX: a bubble in decode never forwards control into execute.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      CtrlE    <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      ValidE   <= 1'b0;
    end else if (FlushE) begin
      CtrlE    <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      ValidE   <= 1'b0;
    end else begin
      CtrlE    <= ValidD ? CtrlD : '0;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
      ValidE   <= ValidD;
    end
  end

  // Event counters: index 0 counts effective stalls, index 1 counts flushes.
  logic [1:0]       eventHit;
  logic [CNT_W-1:0] eventCnt [2];

  assign eventHit = {FlushD, StallD & ~FlushD};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gCnt
      logic [CNT_W-1:0] cntReg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cntReg <= '0;
        end else if (eventHit[gi]) begin
          cntReg <= cntReg + 1'b1;
        end
      end
      assign eventCnt[gi] = cntReg;
    end
  endgenerate

  assign StallCnt = eventCnt[0];
  assign FlushCnt = eventCnt[1];

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: stimulus pushes expectations into a
// scoreboard queue, a monitor pops and compares them after each edge.
module tb_pipe_stage_regs;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;
  localparam int CNT_W  = 4;

  localparam int S_PCF = 0, S_INSTRD = 1, S_PCD = 2, S_VALIDD = 3, S_CTRLE = 4,
                 S_VALIDE = 5, S_RDE = 6, S_PCE = 7, S_STALLCNT = 8,
                 S_FLUSHCNT = 9, S_RDD = 10, S_RS1D = 11;

  logic clk = 1'b0;
  logic reset;
  logic StallF, StallD, FlushD, FlushE;
  logic [XLEN-1:0] PCNextF, InstrF, PCPlus4F;
  logic [XLEN-1:0] PCF, InstrD, PCD, PCPlus4D;
  logic ValidD;
  logic [CTRL_W-1:0] CtrlD, CtrlE;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic ValidE;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  logic branchTaken;
  logic probe = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  typedef struct {
    int          tag;
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  pipe_stage_regs #(
    .XLEN(XLEN), .CTRL_W(CTRL_W), .RESET_PC(32'h0000_0100), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ValidE(ValidE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tiny instruction memory plus the fetch-side adders.
  function automatic logic [31:0] imemRead(input logic [31:0] pc);
    case (pc)
      32'h100: imemRead = 32'h00A0_0093;
      32'h104: imemRead = 32'h0050_0113;
      32'h108: imemRead = 32'h0020_81B3;
      32'h120: imemRead = 32'h00C0_0313;
      32'h124: imemRead = 32'h00A0_0093;
      default: imemRead = 32'h0000_0013;
    endcase
  endfunction

  assign InstrF   = imemRead(PCF);
  assign PCPlus4F = PCF + 32'd4;
  assign PCNextF  = branchTaken ? 32'h0000_0120 : PCF + 32'd4;

  function automatic logic [31:0] getVal(input int sel);
    case (sel)
      S_PCF:      getVal = PCF;
      S_INSTRD:   getVal = InstrD;
      S_PCD:      getVal = PCD;
      S_VALIDD:   getVal = {31'd0, ValidD};
      S_CTRLE:    getVal = {20'd0, CtrlE};
      S_VALIDE:   getVal = {31'd0, ValidE};
      S_RDE:      getVal = {27'd0, RdE};
      S_PCE:      getVal = PCE;
      S_STALLCNT: getVal = {28'd0, StallCnt};
      S_FLUSHCNT: getVal = {28'd0, FlushCnt};
      S_RDD:      getVal = {27'd0, RdD};
      S_RS1D:     getVal = {27'd0, Rs1D};
      default:    getVal = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic pushExp(input int tag, input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.name = name; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  // Monitor: after every edge (or an async-reset probe) check all due entries.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(posedge clk or posedge probe);
      #1;
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        act = getVal(e.sel);
        compared++;
        if (act !== e.exp) begin
          mismatched++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", e.name, cyc, act, e.exp);
        end else begin
          $display("ok   %s (cycle %0d): %h", e.name, cyc, act);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time, got %0d entries pending, expected 0", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    branchTaken = 1'b0;
    CtrlD = 12'hABC; RD1D = 32'h1111_0000; RD2D = 32'h2222_0000; ImmExtD = 32'h0000_0044;

    // Reset state, reset still asserted at the next edge
    repeat (2) @(negedge clk);
    pushExp(cyc + 1, "rst_pcf", S_PCF, 32'h100);
    pushExp(cyc + 1, "rst_validd", S_VALIDD, 0);
    pushExp(cyc + 1, "rst_valide", S_VALIDE, 0);
    pushExp(cyc + 1, "rst_instrd", S_INSTRD, 0);
    pushExp(cyc + 1, "rst_ctrle", S_CTRLE, 0);
    pushExp(cyc + 1, "rst_stallcnt", S_STALLCNT, 0);
    pushExp(cyc + 1, "rst_flushcnt", S_FLUSHCNT, 0);

    // 1. Release: first fetch at RESET_PC, ValidD from the first edge
    @(negedge clk); reset = 1'b0;
    pushExp(cyc + 1, "seq_pcf_104", S_PCF, 32'h104);
    pushExp(cyc + 1, "seq_validd", S_VALIDD, 1);
    pushExp(cyc + 1, "seq_instrd0", S_INSTRD, 32'h00A0_0093);
    pushExp(cyc + 1, "seq_pcd_100", S_PCD, 32'h100);
    pushExp(cyc + 1, "seq_valide0", S_VALIDE, 0);
    pushExp(cyc + 1, "seq_ctrle_bubble", S_CTRLE, 0);

    @(negedge clk);
    pushExp(cyc + 1, "seq_pcf_108", S_PCF, 32'h108);
    pushExp(cyc + 1, "seq_instrd1", S_INSTRD, 32'h0050_0113);
    pushExp(cyc + 1, "seq_rdd", S_RDD, 2);
    pushExp(cyc + 1, "seq_rde", S_RDE, 1);
    pushExp(cyc + 1, "seq_valide1", S_VALIDE, 1);
    pushExp(cyc + 1, "seq_ctrle", S_CTRLE, 32'hABC);
    pushExp(cyc + 1, "seq_pce", S_PCE, 32'h100);

    // 2. Load-use stall with execute bubble
    @(negedge clk); StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    pushExp(cyc + 1, "lu_pcf_held", S_PCF, 32'h108);
    pushExp(cyc + 1, "lu_instrd_held", S_INSTRD, 32'h0050_0113);
    pushExp(cyc + 1, "lu_validd", S_VALIDD, 1);
    pushExp(cyc + 1, "lu_valide", S_VALIDE, 0);
    pushExp(cyc + 1, "lu_ctrle", S_CTRLE, 0);
    pushExp(cyc + 1, "lu_rde", S_RDE, 0);
    pushExp(cyc + 1, "lu_stallcnt", S_STALLCNT, 1);
    pushExp(cyc + 1, "lu_flushcnt", S_FLUSHCNT, 0);

    @(negedge clk); StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0;
    pushExp(cyc + 1, "lu2_pcf", S_PCF, 32'h10C);
    pushExp(cyc + 1, "lu2_instrd", S_INSTRD, 32'h0020_81B3);
    pushExp(cyc + 1, "lu2_rs1d", S_RS1D, 1);
    pushExp(cyc + 1, "lu2_rde", S_RDE, 2);
    pushExp(cyc + 1, "lu2_valide", S_VALIDE, 1);
    pushExp(cyc + 1, "lu2_pce", S_PCE, 32'h104);
    pushExp(cyc + 1, "lu2_stallcnt", S_STALLCNT, 1);

    // 3. Taken branch flushes decode and execute
    @(negedge clk); FlushD = 1'b1; FlushE = 1'b1; branchTaken = 1'b1;
    pushExp(cyc + 1, "br_pcf", S_PCF, 32'h120);
    pushExp(cyc + 1, "br_instrd", S_INSTRD, 0);
    pushExp(cyc + 1, "br_validd", S_VALIDD, 0);
    pushExp(cyc + 1, "br_pcd", S_PCD, 0);
    pushExp(cyc + 1, "br_rdd", S_RDD, 0);
    pushExp(cyc + 1, "br_valide", S_VALIDE, 0);
    pushExp(cyc + 1, "br_rde", S_RDE, 0);
    pushExp(cyc + 1, "br_ctrle", S_CTRLE, 0);
    pushExp(cyc + 1, "br_flushcnt", S_FLUSHCNT, 1);
    pushExp(cyc + 1, "br_stallcnt", S_STALLCNT, 1);

    @(negedge clk); FlushD = 1'b0; FlushE = 1'b0; branchTaken = 1'b0;
    pushExp(cyc + 1, "br2_pcf", S_PCF, 32'h124);
    pushExp(cyc + 1, "br2_instrd", S_INSTRD, 32'h00C0_0313);
    pushExp(cyc + 1, "br2_rdd", S_RDD, 6);
    pushExp(cyc + 1, "br2_pcd", S_PCD, 32'h120);
    pushExp(cyc + 1, "br2_valide_bubble", S_VALIDE, 0);
    pushExp(cyc + 1, "br2_ctrle_bubble", S_CTRLE, 0);

    // 4. Stall and flush together: flush wins, PC held by StallF
    @(negedge clk); StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1;
    pushExp(cyc + 1, "sf_pcf_held", S_PCF, 32'h124);
    pushExp(cyc + 1, "sf_instrd", S_INSTRD, 0);
    pushExp(cyc + 1, "sf_validd", S_VALIDD, 0);
    pushExp(cyc + 1, "sf_stallcnt", S_STALLCNT, 1);
    pushExp(cyc + 1, "sf_flushcnt", S_FLUSHCNT, 2);
    pushExp(cyc + 1, "sf_valide", S_VALIDE, 1);
    pushExp(cyc + 1, "sf_rde", S_RDE, 6);
    pushExp(cyc + 1, "sf_ctrle", S_CTRLE, 32'hABC);
    pushExp(cyc + 1, "sf_pce", S_PCE, 32'h120);

    @(negedge clk); StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    pushExp(cyc + 1, "sf2_pcf", S_PCF, 32'h128);
    pushExp(cyc + 1, "sf2_instrd", S_INSTRD, 32'h00A0_0093);
    pushExp(cyc + 1, "sf2_validd", S_VALIDD, 1);
    pushExp(cyc + 1, "sf2_valide", S_VALIDE, 0);

    // 5. Asynchronous reset mid-cycle, checked before the next edge
    @(negedge clk);
    #2 reset = 1'b1;
    pushExp(cyc, "ar_pcf", S_PCF, 32'h100);
    pushExp(cyc, "ar_instrd", S_INSTRD, 0);
    pushExp(cyc, "ar_validd", S_VALIDD, 0);
    pushExp(cyc, "ar_pcd", S_PCD, 0);
    pushExp(cyc, "ar_rdd", S_RDD, 0);
    pushExp(cyc, "ar_valide", S_VALIDE, 0);
    pushExp(cyc, "ar_ctrle", S_CTRLE, 0);
    pushExp(cyc, "ar_rde", S_RDE, 0);
    pushExp(cyc, "ar_stallcnt", S_STALLCNT, 0);
    pushExp(cyc, "ar_flushcnt", S_FLUSHCNT, 0);
    probe = 1'b1;
    #2 probe = 1'b0;

    @(negedge clk); reset = 1'b0;
    pushExp(cyc + 1, "ar2_pcf", S_PCF, 32'h104);
    pushExp(cyc + 1, "ar2_instrd", S_INSTRD, 32'h00A0_0093);
    pushExp(cyc + 1, "ar2_validd", S_VALIDD, 1);

    // 6. Stall counter wraps modulo 2^CNT_W
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); StallF = 1'b1; StallD = 1'b1;
      pushExp(cyc + 1, $sformatf("wrap_stallcnt_%0d", i), S_STALLCNT, 32'(i % 16));
    end
    pushExp(cyc + 1, "wrap_pcf_held", S_PCF, 32'h104);

    @(negedge clk); StallF = 1'b0; StallD = 1'b0;
    pushExp(cyc + 1, "wrap_idle_stallcnt", S_STALLCNT, 0);
    pushExp(cyc + 1, "wrap_flushcnt", S_FLUSHCNT, 0);
    pushExp(cyc + 1, "wrap_pcf_run", S_PCF, 32'h108);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
